pulse_shrink: RTL and testbench

Receive-side partner of the pulse-hold stretcher. Takes a stretched or held level, such as a held trigger, a button level or a signal from another clock domain. Synchronises it, requires it to stay high for a minimum time, and emits exactly one single-cycle pulse per qualified assertion. The block re-arms only after the input has been low for a minimum time. It sits between stretched/asynchronous event sources and single-cycle-event consumers, e.g. game-control FSMs.

---
 rtl/pulse_shrink.sv | 124 ++++++++++++
 tb/tb_pulse_shrink.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_shrink.sv
// Level-to-pulse shrinker: synchronises a held level, qualifies its
// high time, emits one pulse per assertion and re-arms after a low run.
module pulse_shrink #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [5:0]  MIN_HIGH    = 6'd4,
  parameter logic [5:0]  MIN_LOW     = 6'd4
) (
  input  logic clk,
  input  logic rst_p,
  input  logic level_i,
  output logic pulse_o,
  output logic glitch_o,
  output logic busy_o
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    QUAL     = 3'd1,
    WAIT_LOW = 3'd2,
    RELEASE  = 3'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  state_t     state_q;
  state_t     state_d;
  logic [5:0] cnt_q;
  logic [5:0] cnt_d;
  logic [5:0] cnt_inc;
  logic       fire;
  logic       glitch;

  assign s       = sync_q[SYNC_STAGES-1];
  assign cnt_inc = cnt_q + 6'd1;

  // Synchroniser chain for the asynchronous level input
  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], level_i};
    end
  end

  // State, run counter and registered outputs
  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      state_q  <= IDLE;
      cnt_q    <= 6'd0;
      pulse_o  <= 1'b0;
      glitch_o <= 1'b0;
      busy_o   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pulse_o  <= fire;
      glitch_o <= glitch;
      busy_o   <= (state_d != IDLE);
    end
  end

  // Next-state: qualify the high run, fire once, then wait out the low run
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fire    = 1'b0;
    glitch  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!s) begin
          cnt_d = 6'd0;
        end else if (MIN_HIGH == 6'd1) begin
          state_d = WAIT_LOW;
          fire    = 1'b1;
          cnt_d   = 6'd0;
        end else begin
          state_d = QUAL;
          cnt_d   = 6'd1;
        end
      end
      QUAL: begin
        if (!s) begin
          state_d = IDLE;
          glitch  = 1'b1;
          cnt_d   = 6'd0;
        end else if (cnt_inc == MIN_HIGH) begin
          state_d = WAIT_LOW;
          fire    = 1'b1;
          cnt_d   = 6'd0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      WAIT_LOW: begin
        if (s) begin
          cnt_d = 6'd0;
        end else if (MIN_LOW == 6'd1) begin
          state_d = IDLE;
          cnt_d   = 6'd0;
        end else begin
          state_d = RELEASE;
          cnt_d   = 6'd1;
        end
      end
      RELEASE: begin
        if (s) begin
          state_d = WAIT_LOW;
          cnt_d   = 6'd0;
        end else if (cnt_inc == MIN_LOW) begin
          state_d = IDLE;
          cnt_d   = 6'd0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 6'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_pulse_shrink.sv
// Bench for pulse_shrink: vector table, directed corner sequences and
// randomized runs checked against a run-length reference model.
module tb_pulse_shrink;

  logic clk = 1'b0;
  logic rst_p;
  logic lvl_a, lvl_b;
  logic pulse_a, glitch_a, busy_a;
  logic pulse_b, glitch_b, busy_b;

  always #5 clk = ~clk;

  pulse_shrink #(
    .SYNC_STAGES(2), .MIN_HIGH(6'd4), .MIN_LOW(6'd4)
  ) dut_a (
    .clk(clk), .rst_p(rst_p), .level_i(lvl_a),
    .pulse_o(pulse_a), .glitch_o(glitch_a), .busy_o(busy_a)
  );

  pulse_shrink #(
    .SYNC_STAGES(3), .MIN_HIGH(6'd1), .MIN_LOW(6'd1)
  ) dut_b (
    .clk(clk), .rst_p(rst_p), .level_i(lvl_b),
    .pulse_o(pulse_b), .glitch_o(glitch_b), .busy_o(busy_b)
  );

  int ss_p[2] = '{2, 3};
  int mh_p[2] = '{4, 1};
  int ml_p[2] = '{4, 1};

  // reference model state: input history, armed flag, run lengths
  logic hist[2][4];
  bit   armed[2];
  int   hi_run[2];
  int   lo_run[2];
  logic mp[2], mg[2], mb[2];

  int ncmp = 0;
  int nfail = 0;
  int edge_n = 0;
  int npulse[2];
  int nglitch[2];
  int rise_edge[2];

  task automatic chk(input string name, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)",
               name, act, exp, edge_n - 1);
    end
  endtask

  // one clock edge of the behavioural model
  task automatic model_edge(input int d, input logic lvl, input logic rst);
    logic s;
    if (rst) begin
      for (int i = 0; i < 4; i++) hist[d][i] = 1'b0;
      armed[d] = 1'b1;
      hi_run[d] = 0;
      lo_run[d] = 0;
      mp[d] = 1'b0;
      mg[d] = 1'b0;
      mb[d] = 1'b0;
      return;
    end
    s = hist[d][ss_p[d]-1];
    for (int i = 3; i > 0; i--) hist[d][i] = hist[d][i-1];
    hist[d][0] = lvl;
    mp[d] = 1'b0;
    mg[d] = 1'b0;
    if (armed[d]) begin
      if (s) begin
        hi_run[d]++;
        if (hi_run[d] == mh_p[d]) begin
          mp[d] = 1'b1;
          armed[d] = 1'b0;
          hi_run[d] = 0;
          lo_run[d] = 0;
        end
      end else begin
        if (hi_run[d] > 0) mg[d] = 1'b1;
        hi_run[d] = 0;
      end
    end else begin
      if (s) begin
        lo_run[d] = 0;
      end else begin
        lo_run[d]++;
        if (lo_run[d] == ml_p[d]) begin
          armed[d] = 1'b1;
          hi_run[d] = 0;
        end
      end
    end
    mb[d] = !armed[d] || (hi_run[d] > 0);
  endtask

  // drive levels, take one edge, compare both DUTs to the model
  task automatic step(input logic la, input logic lb);
    lvl_a = la;
    lvl_b = lb;
    @(posedge clk);
    model_edge(0, la, rst_p);
    model_edge(1, lb, rst_p);
    edge_n++;
    #1;
    chk("model_a", int'({pulse_a, glitch_a, busy_a}),
        int'({mp[0], mg[0], mb[0]}));
    chk("model_b", int'({pulse_b, glitch_b, busy_b}),
        int'({mp[1], mg[1], mb[1]}));
    if (pulse_a) begin npulse[0]++; rise_edge[0] = edge_n - 1; end
    if (pulse_b) begin npulse[1]++; rise_edge[1] = edge_n - 1; end
    if (glitch_a) nglitch[0]++;
    if (glitch_b) nglitch[1]++;
    if (pulse_a && glitch_a) chk("excl_a", 1, 0);
    if (pulse_b && glitch_b) chk("excl_b", 1, 0);
    @(negedge clk);
  endtask

  task automatic clr_counts();
    for (int d = 0; d < 2; d++) begin
      npulse[d] = 0;
      nglitch[d] = 0;
      rise_edge[d] = -1;
    end
  endtask

  task automatic do_reset(input int n);
    rst_p = 1'b1;
    repeat (n) step(1'b0, 1'b0);
    rst_p = 1'b0;
  endtask

  typedef struct {
    logic lvl;
    logic p;
    logic g;
    logic b;
  } vec_t;

  vec_t tbl[24];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int k;
    int any_hi;
    int rem_a, rem_b;
    logic cur_a, cur_b;

    // glitch: 3 high cycles then low
    tbl[0] = '{1, 0, 0, 0}; tbl[1] = '{1, 0, 0, 0};
    tbl[2] = '{1, 0, 0, 1}; tbl[3] = '{0, 0, 0, 1};
    tbl[4] = '{0, 0, 0, 1}; tbl[5] = '{0, 0, 1, 0};
    tbl[6] = '{0, 0, 0, 0}; tbl[7] = '{0, 0, 0, 0};
    // 10 high cycles then low: pulse at edge 5, re-arm at edge 15
    for (int i = 0; i < 16; i++) begin
      tbl[8+i].lvl = (i < 10);
      tbl[8+i].p   = (i == 5);
      tbl[8+i].g   = 1'b0;
      tbl[8+i].b   = (i >= 2 && i <= 14);
    end

    rst_p = 1'b1;
    lvl_a = 1'b0;
    lvl_b = 1'b0;
    model_edge(0, 1'b0, 1'b1);
    model_edge(1, 1'b0, 1'b1);
    clr_counts();
    @(negedge clk);

    // 1: reset then quiet input
    do_reset(5);
    any_hi = 0;
    repeat (20) begin
      step(1'b0, 1'b0);
      if (pulse_a || glitch_a || busy_a) any_hi = 1;
    end
    chk("quiet_outputs", any_hi, 0);

    // vector table on the default instance
    foreach (tbl[i]) begin
      step(tbl[i].lvl, 1'b0);
      chk("tbl_vec", int'({pulse_a, glitch_a, busy_a}),
          int'({tbl[i].p, tbl[i].g, tbl[i].b}));
    end

    // 2: long hold, exactly one pulse, exact latency
    do_reset(2);
    clr_counts();
    base = edge_n;
    repeat (60) step(1'b1, 1'b0);
    chk("hold_npulse", npulse[0], 1);
    chk("hold_rise", rise_edge[0] - base, 5);
    chk("hold_glitch", nglitch[0], 0);
    k = 0;
    do begin
      step(1'b0, 1'b0);
      k++;
    end while (busy_a && k < 20);
    chk("busy_fall", k - 1, 5);
    chk("busy_low", int'(busy_a), 0);
    repeat (4) step(1'b0, 1'b0);

    // 3: short high is a glitch
    clr_counts();
    repeat (3) step(1'b1, 1'b0);
    repeat (8) step(1'b0, 1'b0);
    chk("short_npulse", npulse[0], 0);
    chk("short_nglitch", nglitch[0], 1);
    chk("short_busy", int'(busy_a), 0);

    // 4: re-arm needs MIN_LOW low samples
    clr_counts();
    repeat (10) step(1'b1, 1'b0);
    repeat (2) step(1'b0, 1'b0);
    repeat (10) step(1'b1, 1'b0);
    repeat (12) step(1'b0, 1'b0);
    chk("gap2_npulse", npulse[0], 1);
    clr_counts();
    repeat (10) step(1'b1, 1'b0);
    repeat (10) step(1'b0, 1'b0);
    repeat (10) step(1'b1, 1'b0);
    repeat (12) step(1'b0, 1'b0);
    chk("gap10_npulse", npulse[0], 2);

    // 5: reset during qualification, input still high afterwards
    clr_counts();
    repeat (3) step(1'b1, 1'b0);
    rst_p = 1'b1;
    step(1'b1, 1'b0);
    rst_p = 1'b0;
    chk("rst_qual_npulse", npulse[0], 0);
    base = edge_n;
    repeat (20) step(1'b1, 1'b0);
    chk("post_rst_npulse", npulse[0], 1);
    chk("post_rst_rise", rise_edge[0] - base, 5);
    repeat (10) step(1'b0, 1'b0);

    // 6: SYNC_STAGES=3, MIN_HIGH=1, MIN_LOW=1 instance
    clr_counts();
    base = edge_n;
    step(1'b0, 1'b1);
    repeat (6) step(1'b0, 1'b0);
    chk("b_npulse", npulse[1], 1);
    chk("b_rise", rise_edge[1] - base, 3);
    clr_counts();
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    repeat (8) step(1'b0, 1'b0);
    chk("b_hlh_npulse", npulse[1], 2);
    chk("b_hlh_glitch", nglitch[1], 0);

    // randomized runs with occasional reset
    rem_a = 0;
    rem_b = 0;
    cur_a = 1'b0;
    cur_b = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      if (rem_a == 0) begin
        cur_a = ~cur_a;
        rem_a = ($urandom_range(0, 15) == 0) ?
                int'($urandom_range(60, 80)) :
                int'($urandom_range(1, 9));
      end
      if (rem_b == 0) begin
        cur_b = ~cur_b;
        rem_b = int'($urandom_range(1, 4));
      end
      rst_p = ($urandom_range(0, 299) == 0);
      step(cur_a, cur_b);
      rem_a--;
      rem_b--;
    end
    rst_p = 1'b0;
    repeat (4) step(1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
